// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants and FSM state type for the instruction-memory loader
package imem_pkg;

    localparam int MEM_BYTES      = 256;
    localparam int BYTES_PER_WORD = 4;
    localparam int IMEM_WORD_W    = 32;
    localparam int MAX_WORDS      = MEM_BYTES / BYTES_PER_WORD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/imem_byte_sel.sv
// rtl/imem_byte_sel.sv - big-endian byte lane select: index 0 picks the most significant byte
module imem_byte_sel
    import imem_pkg::*;
(
    input  logic [IMEM_WORD_W-1:0] word_i,
    input  logic [1:0]             byte_idx_i,
    output logic [7:0]             byte_o
);

    always_comb begin
        byte_o = 8'h00;
        case (byte_idx_i)
            2'd0:    byte_o = word_i[31:24];
            2'd1:    byte_o = word_i[23:16];
            2'd2:    byte_o = word_i[15:8];
            default: byte_o = word_i[7:0];
        endcase
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - accepts instruction words and writes them bytewise into instruction memory
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [6:0]        words_written
);

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic [1:0]        byte_idx_q;
    logic [WORD_W-1:0] data_q;
    logic              last_q;
    logic [6:0]        words_q;
    logic [6:0]        words_d;
    logic              error_q;
    logic              done_q;
    logic              in_ready_q;
    logic              busy_q;
    logic              mem_we_q;
    logic [7:0]        sel_byte;

    imem_byte_sel u_byte_sel (
        .word_i     (data_q),
        .byte_idx_i (byte_idx_q),
        .byte_o     (sel_byte)
    );

    // ptr_d wrapping to zero after the last byte of a word means the memory is full
    assign ptr_d   = ptr_q + ADDR_W'(1);
    assign words_d = (words_q == 7'(MAX_WORDS)) ? words_q : words_q + 7'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            byte_idx_q <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            words_q    <= '0;
            error_q    <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ptr_q      <= base_addr & ~ADDR_W'(3);
                        words_q    <= '0;
                        error_q    <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    if (in_valid) begin
                        data_q     <= in_data;
                        last_q     <= in_last;
                        byte_idx_q <= '0;
                        in_ready_q <= 1'b0;
                        mem_we_q   <= 1'b1;
                        state_q    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    ptr_q      <= ptr_d;
                    byte_idx_q <= byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        mem_we_q <= 1'b0;
                        words_q  <= words_d;
                        if (last_q) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else if (ptr_d == '0) begin
                            error_q <= 1'b1;
                            state_q <= ST_ERR;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= ST_ACCEPT;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_we_q ? ptr_q : '0;
    assign mem_wdata     = mem_we_q ? sel_byte : 8'h00;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a session-level model
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [6:0]  words_written;

    imem_loader #(.ADDR_W(8), .WORD_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic [15:0] got_q[$];
    logic [31:0] w_q[$];
    bit          l_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) got_q.push_back({mem_addr, mem_wdata});
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // Model: walk the word list byte by byte; the session ends at the first
    // word flagged last, or when the address wraps past the top of memory.
    task automatic run_session(input logic [7:0] base, input bit noise, input bit spacing);
        logic [7:0]  p;
        logic [31:0] w;
        logic [15:0] exp_q[$];
        int          acc[$];
        int          cnt;
        int          n;
        int          rdy_seen;
        bit          e_done;
        bit          e_err;
        p = base & 8'hFC;
        cnt = 0;
        e_done = 0;
        e_err = 0;
        for (int i = 0; i < w_q.size(); i++) begin
            w = w_q[i];
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back({p, w[31-8*b -: 8]});
                p = p + 8'd1;
            end
            cnt++;
            if (l_q[i]) begin
                e_done = 1;
                break;
            end
            if (p == 8'h00) begin
                e_err = 1;
                break;
            end
        end

        got_q.delete();
        done_cnt = 0;
        start = 1'b1;
        base_addr = base;
        @(negedge clk);
        start = 1'b0;
        base_addr = 8'($urandom);
        check("start_busy", busy, 1);
        check("start_err_clr", error, 0);
        check("start_ww_clr", words_written, 0);

        for (int i = 0; i < cnt; i++) begin
            if (!spacing) repeat ($urandom_range(0, 2)) @(negedge clk);
            in_valid = 1'b1;
            in_data = w_q[i];
            in_last = l_q[i];
            n = 0;
            while (!in_ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("ready_timeout", n < 40, 1);
            acc.push_back(cyc);
            @(negedge clk);
            if (noise) begin
                for (int j = 0; j < 4; j++) begin
                    start = 1'($urandom_range(0, 1));
                    in_valid = 1'($urandom_range(0, 1));
                    in_data = $urandom;
                    in_last = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                start = 1'b0;
                in_valid = 1'b0;
                in_last = 1'b0;
            end else if (!spacing) begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        start = 1'b0;

        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("busy_timeout", n < 100, 1);
        @(negedge clk);

        check("done_pulses", done_cnt, e_done);
        check("error_flag", error, e_err);
        check("words_written", words_written, cnt);
        check_idle_outputs("post");
        check("byte_count", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check($sformatf("byte%0d", k), got_q[k], exp_q[k]);
        if (spacing)
            for (int k = 1; k < acc.size(); k++)
                check("accept_spacing", acc[k] - acc[k-1], 5);
        if (e_err) begin
            rdy_seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (in_ready) rdy_seen++;
            end
            check("err_no_ready", rdy_seen, 0);
            check("err_sticky", error, 1);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        base_addr = 8'h00;
        in_valid = 1'b0;
        in_data = 32'h0;
        in_last = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_error", error, 0);
        check("reset_ww", words_written, 0);
        rst = 1'b0;
        @(negedge clk);

        w_q = '{32'h8C010004};
        l_q = '{1'b1};
        run_session(8'h00, 0, 0);
        check("single_first_byte", got_q.size() > 0 ? got_q[0] : 16'hxxxx, 16'h008C);
        check("single_last_byte", got_q.size() > 3 ? got_q[3] : 16'hxxxx, 16'h0304);

        w_q = '{$urandom, $urandom, $urandom};
        l_q = '{1'b0, 1'b0, 1'b1};
        run_session(8'h13, 0, 1);
        check("aligned_base", got_q.size() > 0 ? got_q[0][15:8] : 8'hxx, 8'h10);

        w_q = '{32'hFFFFFFFF};
        l_q = '{1'b0};
        run_session(8'hFC, 0, 0);

        w_q = '{$urandom};
        l_q = '{1'b1};
        run_session(8'hFC, 0, 0);

        w_q = '{$urandom, $urandom};
        l_q = '{1'b0, 1'b1};
        run_session(8'h80, 1, 0);

        w_q.delete();
        l_q.delete();
        for (int i = 0; i < 64; i++) begin
            w_q.push_back($urandom);
            l_q.push_back(1'b0);
        end
        run_session(8'h00, 0, 0);

        for (int s = 0; s < 25; s++) begin
            int nw;
            nw = $urandom_range(1, 6);
            w_q.delete();
            l_q.delete();
            for (int i = 0; i < nw; i++) begin
                w_q.push_back($urandom);
                l_q.push_back(i == nw - 1 || $urandom_range(0, 7) == 0);
            end
            run_session(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        got_q.delete();
        start = 1'b1;
        base_addr = 8'h40;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hA1B2C3D4;
        in_last = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rst_ready_timeout", n < 40, 1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_we", mem_we, 1);
        check("rst_mid_addr", mem_addr, 8'h41);
        check("rst_mid_data", mem_wdata, 8'hB2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("rst_mid");
        check("rst_mid_error", error, 0);
        check("rst_mid_ww", words_written, 0);
        repeat (6) @(negedge clk);
        check("rst_abandon_bytes", got_q.size(), 2);
        check("rst_stays_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
